// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between 16 requesters and the round-robin arbiter.
// Handshake: the arbiter samples req and enable at each rising clk edge; grant, grant_id,
// grant_valid and timeout are registered and change only on that edge. A requester keeps its
// req bit high for as long as it wants the resource; dropping it ends its tenure.
interface rr_arbiter_16_if;
  logic        enable;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout;
  logic        dbg_state;

  modport master (
    output enable, req,
    input  grant, grant_id, grant_valid, timeout, dbg_state
  );

  modport slave (
    input  enable, req,
    output grant, grant_id, grant_valid, timeout, dbg_state
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with registered one-hot grant and a bounded hold time per tenure.
// A release re-arbitrates in the same cycle, so back-to-back tenures have no idle bubble.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter_16_if.slave arb
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [15:0]         grant_q, grant_d;
  logic [3:0]          gid_q, gid_d;
  logic                gvalid_q, gvalid_d;
  logic                timeout_q, timeout_d;

  logic [15:0] search_vec;
  logic [3:0]  search_start;
  logic [31:0] search_dbl;
  logic [15:0] search_rot;
  logic [3:0]  search_off;
  logic [3:0]  winner;
  logic        found;
  logic        own_req;
  logic        hold_hit;
  logic        release_now;

  assign own_req     = arb.req[gid_q];
  assign hold_hit    = own_req && (hold_q == HOLD_W'(MAX_HOLD));
  assign release_now = (state_q == S_GRANT) && (!own_req || hold_hit);

  // On a normal release the owner is masked out; on a timeout it stays eligible but,
  // because the search starts at owner+1, it is naturally visited last.
  always_comb begin
    search_vec   = arb.req;
    search_start = ptr_q;
    if (state_q == S_GRANT) begin
      search_start = gid_q + 4'd1;
      if (!hold_hit) search_vec = arb.req & ~(16'h0001 << gid_q);
    end
    search_dbl = {search_vec, search_vec} >> search_start;
    search_rot = search_dbl[15:0];
    search_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (search_rot[i]) search_off = 4'(i);
    end
    winner = search_start + search_off;
    found  = |search_vec;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    gvalid_d  = gvalid_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_d  = 16'h0000;
        gid_d    = 4'd0;
        gvalid_d = 1'b0;
        if (arb.enable && found) begin
          state_d  = S_GRANT;
          grant_d  = 16'h0001 << winner;
          gid_d    = winner;
          gvalid_d = 1'b1;
          hold_d   = HOLD_W'(1);
        end
      end
      S_GRANT: begin
        if (!release_now) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          ptr_d     = gid_q + 4'd1;
          timeout_d = hold_hit;
          if (arb.enable && found) begin
            grant_d  = 16'h0001 << winner;
            gid_d    = winner;
            gvalid_d = 1'b1;
            hold_d   = HOLD_W'(1);
          end else begin
            state_d  = S_IDLE;
            grant_d  = 16'h0000;
            gid_d    = 4'd0;
            gvalid_d = 1'b0;
            hold_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 4'd0;
      hold_q    <= '0;
      grant_q   <= 16'h0000;
      gid_q     <= 4'd0;
      gvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      gvalid_q  <= gvalid_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_id    = gid_q;
  assign arb.grant_valid = gvalid_q;
  assign arb.timeout     = timeout_q;
  assign arb.dbg_state   = (state_q == S_GRANT);

endmodule
